image_loader: RTL and testbench

Streaming front end for the `deep` inference core. It receives one frame per inference as a stream of 32-bit words over a valid/ready handshake: one label word followed by 784 pixel words. It assembles the frame into the parallel `image_in`/`label_in` buses that `deep` consumes, then pulses `start` and holds the frame stable until `deep` reports `done`. It drives the input side of the interface that `deep` receives.

---
 rtl/deep_pkg.sv | 16 +
 rtl/image_loader.sv | 90 +++++++++
 tb/tb_image_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/deep_pkg.sv
// Shared shape of the image bus between the stream loader and the deep inference core.
package deep_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int WORD_W     = 32;
    localparam int LABEL_W    = 8;
    localparam int PIX_CNT_W  = $clog2(NUM_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT
    } loader_state_t;

endpackage

// File: rtl/image_loader.sv
// Streaming front end for deep: collects label + pixel words into the parallel image bus,
// fires start once per complete frame and holds the frame until deep reports done.
module image_loader
    import deep_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WORD_W-1:0]                     in_data,
    input  logic                                  in_last,
    output logic                                  start,
    output logic [LABEL_W-1:0]                    label_out,
    output logic [NUM_PIXELS-1:0][WORD_W-1:0]     image_out,
    input  logic                                  net_done,
    output logic                                  busy,
    output logic                                  frame_err
);

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(NUM_PIXELS - 1);

    loader_state_t                         state_q;
    logic [PIX_CNT_W-1:0]                  pix_cnt_q;
    logic [LABEL_W-1:0]                    label_q;
    logic [NUM_PIXELS-1:0][WORD_W-1:0]     image_q;
    logic                                  frame_err_q;
    logic                                  at_last_pix;

    // Handshake and status are pure state decodes so deep never sees a combinational input path.
    assign in_ready    = (state_q == IDLE) || (state_q == LOAD);
    assign start       = (state_q == FIRE);
    assign busy        = (state_q == FIRE) || (state_q == WAIT);
    assign frame_err   = frame_err_q;
    assign label_out   = label_q;
    assign image_out   = image_q;
    assign at_last_pix = (pix_cnt_q == LAST_PIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            label_q     <= '0;
            image_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        label_q   <= in_data[LABEL_W-1:0];
                        pix_cnt_q <= '0;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        image_q[pix_cnt_q] <= in_data;
                        // The counter parks on the last index; any mismatch with in_last drops the frame.
                        if (at_last_pix) begin
                            if (in_last) begin
                                state_q <= FIRE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= IDLE;
                            end
                        end else begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                            if (in_last) begin
                                frame_err_q <= 1'b1;
                                state_q     <= IDLE;
                            end
                        end
                    end
                end
                FIRE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (net_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader: nominal, backpressure, malformed, gapped and reset frames.
module tb_image_loader;
    import deep_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst = 1'b1;
    logic                               in_valid = 1'b0;
    logic                               in_ready;
    logic [WORD_W-1:0]                  in_data = '0;
    logic                               in_last = 1'b0;
    logic                               start;
    logic [LABEL_W-1:0]                 label_out;
    logic [NUM_PIXELS-1:0][WORD_W-1:0]  image_out;
    logic                               net_done = 1'b0;
    logic                               busy;
    logic                               frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int start_cycle = 0;

    image_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .start     (start),
        .label_out (label_out),
        .image_out (image_out),
        .net_done  (net_done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle n is the one that begins at edge n-1, so a pulse seen mid-cycle belongs to cycle cyc+1.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cnt++;
            start_cycle = cyc + 1;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic last, output int edge_no);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && guard < 2000) begin
            step();
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        step();
        edge_no  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Label word carries junk in its upper bits and in_last=1, both of which must be ignored.
    task automatic send_frame(input logic [LABEL_W-1:0] lbl, input logic [WORD_W-1:0] base,
                              input int n_pix, input int last_idx, input bit gapped,
                              output int label_edge, output int last_edge);
        send_word({24'hA5A5A5, lbl}, 1'b1, label_edge);
        last_edge = label_edge;
        for (int k = 0; k < n_pix; k++) begin
            if (gapped) begin
                int g;
                g = $urandom_range(0, 1);
                for (int j = 0; j < g; j++) step();
            end
            send_word(base + WORD_W'(k), (k == last_idx), last_edge);
        end
    endtask

    task automatic pulse_done();
        net_done = 1'b1;
        step();
        net_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b want 0", start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (label_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_label: got %h want 00", label_out); end
        checks++; if (image_out !== '0) begin errors++; $display("[TB] FAIL reset_image: got nonzero want all 0"); end
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_nominal();
        int le, fe, bad, s0;
        s0 = start_cnt;
        send_frame(8'h07, 32'h1000, NUM_PIXELS, NUM_PIXELS - 1, 1'b0, le, fe);
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL nom_start: got %b want 1", start); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL nom_in_ready_fire: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nom_busy_fire: got %b want 1", busy); end
        repeat (5) step();
        checks++; if (start_cycle - le != 785) begin errors++; $display("[TB] FAIL nom_latency: got %0d want 785", start_cycle - le); end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("[TB] FAIL nom_start_count: got %0d want 1", start_cnt - s0); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL nom_start_wait: got %b want 0", start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nom_busy_wait: got %b want 1", busy); end
        checks++; if (label_out !== 8'h07) begin errors++; $display("[TB] FAIL nom_label: got %h want 07", label_out); end
        checks++; if (image_out[0] !== 32'h1000) begin errors++; $display("[TB] FAIL nom_pix0: got %h want 00001000", image_out[0]); end
        checks++; if (image_out[783] !== 32'h130F) begin errors++; $display("[TB] FAIL nom_pix783: got %h want 0000130f", image_out[783]); end
        bad = 0;
        for (int k = 0; k < NUM_PIXELS; k++) if (image_out[k] !== 32'h1000 + 32'(k)) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL nom_image: %0d wrong pixels want 0", bad); end
        pulse_done();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nom_done_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nom_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int le, fe;
        send_frame(8'h03, 32'h2000, NUM_PIXELS, NUM_PIXELS - 1, 1'b0, le, fe);
        in_valid = 1'b1;
        in_data  = 32'h0000_00AB;
        in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (label_out !== 8'h03) begin errors++; $display("[TB] FAIL bp_label_held[%0d]: got %h want 03", i, label_out); end
        end
        pulse_done();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_done: got %b want 1", in_ready); end
        checks++; if (label_out !== 8'h03) begin errors++; $display("[TB] FAIL bp_label_after_done: got %h want 03", label_out); end
        step();
        in_valid = 1'b0;
        checks++; if (label_out !== 8'hAB) begin errors++; $display("[TB] FAIL bp_new_label: got %h want ab", label_out); end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_early_last();
        int le, fe, s0, e0, bad;
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(8'h05, 32'h0, 101, 100, 1'b0, le, fe);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL early_frame_err: got %b want 1", frame_err); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL early_start: got %b want 0", start); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL early_in_ready: got %b want 1", in_ready); end
        step();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL early_err_width: got %b want 0", frame_err); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("[TB] FAIL early_err_count: got %0d want 1", err_cnt - e0); end
        send_frame(8'h09, 32'h3000, NUM_PIXELS, NUM_PIXELS - 1, 1'b0, le, fe);
        step();
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("[TB] FAIL early_recover_start: got %0d want 1", start_cnt - s0); end
        checks++; if (label_out !== 8'h09) begin errors++; $display("[TB] FAIL early_recover_label: got %h want 09", label_out); end
        bad = 0;
        for (int k = 0; k < NUM_PIXELS; k++) if (image_out[k] !== 32'h3000 + 32'(k)) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL early_recover_image: %0d wrong pixels want 0", bad); end
        pulse_done();
    endtask

    task automatic test_missing_last();
        int le, fe, s0, e0;
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(8'h11, 32'h0, NUM_PIXELS, -1, 1'b0, le, fe);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL miss_frame_err: got %b want 1", frame_err); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL miss_start: got %b want 0", start); end
        step();
        checks++; if (start_cnt != s0) begin errors++; $display("[TB] FAIL miss_start_count: got %0d want %0d", start_cnt, s0); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("[TB] FAIL miss_err_count: got %0d want 1", err_cnt - e0); end
        send_frame(8'h22, 32'h4000, NUM_PIXELS, NUM_PIXELS - 1, 1'b0, le, fe);
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL miss_next_start: got %b want 1", start); end
        checks++; if (label_out !== 8'h22) begin errors++; $display("[TB] FAIL miss_next_label: got %h want 22", label_out); end
        checks++; if (image_out[783] !== 32'h430F) begin errors++; $display("[TB] FAIL miss_next_pix783: got %h want 0000430f", image_out[783]); end
        pulse_done();
        pulse_done();
    endtask

    task automatic test_gapped();
        int le, fe, bad, s0;
        s0 = start_cnt;
        send_frame(8'h07, 32'h1000, NUM_PIXELS, NUM_PIXELS - 1, 1'b1, le, fe);
        checks++; if (fe - le <= NUM_PIXELS) begin errors++; $display("[TB] FAIL gap_no_gaps: span %0d want > %0d", fe - le, NUM_PIXELS); end
        step();
        checks++; if (start_cycle != fe + 1) begin errors++; $display("[TB] FAIL gap_start_cycle: got %0d want %0d", start_cycle, fe + 1); end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("[TB] FAIL gap_start_count: got %0d want 1", start_cnt - s0); end
        bad = 0;
        for (int k = 0; k < NUM_PIXELS; k++) if (image_out[k] !== 32'h1000 + 32'(k)) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL gap_image: %0d wrong pixels want 0", bad); end
        pulse_done();
    endtask

    task automatic test_reset_mid();
        int le, fe, s0, e0;
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(8'h33, 32'h5000, 401, -1, 1'b0, le, fe);
        rst = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rload_in_ready: got %b want 1", in_ready); end
        checks++; if (label_out !== 8'h00) begin errors++; $display("[TB] FAIL rload_label: got %h want 00", label_out); end
        checks++; if (image_out !== '0) begin errors++; $display("[TB] FAIL rload_image: got nonzero want all 0"); end
        rst = 1'b0;
        net_done = 1'b1;
        repeat (2) step();
        net_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL spurious_done_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL spurious_done_ready: got %b want 1", in_ready); end
        checks++; if (start_cnt != s0 || err_cnt != e0) begin errors++; $display("[TB] FAIL rload_pulses: start %0d err %0d want 0 0", start_cnt - s0, err_cnt - e0); end
        send_frame(8'h44, 32'h6000, NUM_PIXELS, NUM_PIXELS - 1, 1'b0, le, fe);
        repeat (3) step();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rwait_busy_before: got %b want 1", busy); end
        s0 = start_cnt;
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rwait_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rwait_in_ready: got %b want 1", in_ready); end
        checks++; if (label_out !== 8'h00) begin errors++; $display("[TB] FAIL rwait_label: got %h want 00", label_out); end
        checks++; if (image_out !== '0) begin errors++; $display("[TB] FAIL rwait_image: got nonzero want all 0"); end
        rst = 1'b0;
        repeat (3) step();
        checks++; if (start_cnt != s0 || err_cnt != e0) begin errors++; $display("[TB] FAIL rwait_pulses: start %0d err %0d want 0 0", start_cnt - s0, err_cnt - e0); end
    endtask

    initial begin
        $display("[TB] image_loader bench starting");
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_gapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
